// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM pipeline register.
//   ex_mem_payload_t : packed payload carried from EX to MEM
//   EX_MEM_DATA_W / EX_MEM_REG_W / EX_MEM_TOREG_W : default field widths
//   count_valid()    : occupancy from two valid bits
package ex_mem_pkg;

  localparam int EX_MEM_DATA_W  = 32;
  localparam int EX_MEM_REG_W   = 5;
  localparam int EX_MEM_TOREG_W = 2;

  typedef struct packed {
    logic [EX_MEM_DATA_W-1:0]  ALUResult;
    logic [EX_MEM_DATA_W-1:0]  data2;
    logic [EX_MEM_REG_W-1:0]   rd;
    logic                      RegWrite;
    logic                      MemWrite;
    logic                      VRegWrite;
    logic [EX_MEM_TOREG_W-1:0] MemToReg;
  } ex_mem_payload_t;

  function automatic logic [1:0] count_valid(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// ex_mem_slot: one pipeline entry (valid bit + payload).
//   clk, rst : clock, asynchronous active-high reset (valid and payload to 0)
//   load_s   : capture d_s and mark valid
//   clear_s  : drop valid, payload retained; wins over load_s
//   d_s      : payload to capture
//   valid_r  : entry holds a live instruction
//   q_r      : held payload
module ex_mem_slot
  import ex_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_s,
  input  logic            clear_s,
  input  ex_mem_payload_t d_s,
  output logic            valid_r,
  output ex_mem_payload_t q_r
);

  // Valid bit: clear has priority so a flush can never be overridden by a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (clear_s) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: only reset zeroes it; a clear leaves the stale data in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (load_s && !clear_s) begin
      q_r <= d_s;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with valid/ready handshake.
// Build option: define EX_MEM_SKID_EN to add a skid entry and register EX_ready
// (no combinational MEM_ready -> EX_ready path). Without it EX_ready is
// combinational and at most one entry is held.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   EX_valid / EX_ready   : upstream handshake
//   EX_ALUResult, EX_data2, EX_rd, EX_RegWrite, EX_MemWrite, EX_VRegWrite,
//   EX_MemToReg           : upstream payload
//   flush                 : drop every held entry at the next edge
//   MEM_valid / MEM_ready : downstream handshake
//   MEM_*                 : downstream payload (write enables forced 0 when idle)
//   occupancy             : number of held entries
module ex_mem_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int REG_W  = EX_MEM_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_valid,
  output logic              EX_ready,
  input  logic [DATA_W-1:0] EX_ALUResult,
  input  logic [DATA_W-1:0] EX_data2,
  input  logic [REG_W-1:0]  EX_rd,
  input  logic              EX_RegWrite,
  input  logic              EX_MemWrite,
  input  logic              EX_VRegWrite,
  input  logic [1:0]        EX_MemToReg,
  input  logic              flush,
  input  logic              MEM_ready,
  output logic              MEM_valid,
  output logic [DATA_W-1:0] MEM_ALUResult,
  output logic [DATA_W-1:0] MEM_data2,
  output logic [REG_W-1:0]  MEM_rd,
  output logic              MEM_RegWrite,
  output logic              MEM_MemWrite,
  output logic              MEM_VRegWrite,
  output logic [1:0]        MEM_MemToReg,
  output logic [1:0]        occupancy
);

  ex_mem_payload_t ex_payload_s;
  ex_mem_payload_t main_d_s;
  ex_mem_payload_t main_q_r;
  logic            main_valid_r;
  logic            main_load_s;
  logic            main_clear_s;
  logic            accept_s;
  logic            handoff_s;

  assign ex_payload_s = '{ALUResult: EX_ALUResult, data2: EX_data2, rd: EX_rd,
                          RegWrite: EX_RegWrite, MemWrite: EX_MemWrite,
                          VRegWrite: EX_VRegWrite, MemToReg: EX_MemToReg};

  assign accept_s  = EX_valid && EX_ready;
  assign handoff_s = main_valid_r && MEM_ready;

`ifdef EX_MEM_SKID_EN
  ex_mem_payload_t skid_q_r;
  logic            skid_valid_r;
  logic            skid_load_s;
  logic            skid_clear_s;
  logic            skid_next_s;
  logic            ex_ready_r;

  // Steering: skid always drains into main before any newer accept can.
  always_comb begin
    main_load_s  = 1'b0;
    main_clear_s = 1'b0;
    main_d_s     = ex_payload_s;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (flush) begin
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else if (handoff_s) begin
      if (skid_valid_r) begin
        main_load_s  = 1'b1;
        main_d_s     = skid_q_r;
        skid_load_s  = accept_s;
        skid_clear_s = !accept_s;
      end else if (accept_s) begin
        main_load_s = 1'b1;
      end else begin
        main_clear_s = 1'b1;
      end
    end else if (accept_s) begin
      if (main_valid_r) begin
        skid_load_s = 1'b1;
      end else begin
        main_load_s = 1'b1;
      end
    end else begin
      main_load_s = 1'b0;
    end
  end

  // Next skid valid, used to pre-compute the registered ready.
  always_comb begin
    if (skid_clear_s) begin
      skid_next_s = 1'b0;
    end else if (skid_load_s) begin
      skid_next_s = 1'b1;
    end else begin
      skid_next_s = skid_valid_r;
    end
  end

  // Registered ready: mirrors an empty skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ready_r <= 1'b1;
    end else begin
      ex_ready_r <= !skid_next_s;
    end
  end

  ex_mem_slot u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_s  (skid_load_s),
    .clear_s (skid_clear_s),
    .d_s     (ex_payload_s),
    .valid_r (skid_valid_r),
    .q_r     (skid_q_r)
  );

  assign EX_ready  = ex_ready_r;
  assign occupancy = count_valid(main_valid_r, skid_valid_r);
`else
  // Steering: main refills on the same edge it hands off.
  always_comb begin
    main_load_s  = 1'b0;
    main_clear_s = 1'b0;
    main_d_s     = ex_payload_s;
    if (flush) begin
      main_clear_s = 1'b1;
    end else if (accept_s) begin
      main_load_s = 1'b1;
    end else if (handoff_s) begin
      main_clear_s = 1'b1;
    end else begin
      main_load_s = 1'b0;
    end
  end

  assign EX_ready  = !main_valid_r || MEM_ready;
  assign occupancy = count_valid(main_valid_r, 1'b0);
`endif

  ex_mem_slot u_main (
    .clk     (clk),
    .rst     (rst),
    .load_s  (main_load_s),
    .clear_s (main_clear_s),
    .d_s     (main_d_s),
    .valid_r (main_valid_r),
    .q_r     (main_q_r)
  );

  assign MEM_valid     = main_valid_r;
  assign MEM_ALUResult = main_q_r.ALUResult;
  assign MEM_data2     = main_q_r.data2;
  assign MEM_rd        = main_q_r.rd;
  assign MEM_MemToReg  = main_q_r.MemToReg;
  // Write enables are killed while idle so stale payload can never commit.
  assign MEM_RegWrite  = main_valid_r & main_q_r.RegWrite;
  assign MEM_MemWrite  = main_valid_r & main_q_r.MemWrite;
  assign MEM_VRegWrite = main_valid_r & main_q_r.VRegWrite;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed bench for ex_mem_reg with a queue-based reference model.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        vw;
    logic [1:0]  mtr;
  } tb_pl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid;
  logic        EX_ready;
  logic [31:0] EX_ALUResult;
  logic [31:0] EX_data2;
  logic [4:0]  EX_rd;
  logic        EX_RegWrite;
  logic        EX_MemWrite;
  logic        EX_VRegWrite;
  logic [1:0]  EX_MemToReg;
  logic        flush;
  logic        MEM_ready;
  logic        MEM_valid;
  logic [31:0] MEM_ALUResult;
  logic [31:0] MEM_data2;
  logic [4:0]  MEM_rd;
  logic        MEM_RegWrite;
  logic        MEM_MemWrite;
  logic        MEM_VRegWrite;
  logic [1:0]  MEM_MemToReg;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  tb_pl_t mq[$];
  logic [31:0] got[$];
  bit streaming = 1'b0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .EX_valid(EX_valid), .EX_ready(EX_ready),
    .EX_ALUResult(EX_ALUResult), .EX_data2(EX_data2), .EX_rd(EX_rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemWrite(EX_MemWrite),
    .EX_VRegWrite(EX_VRegWrite), .EX_MemToReg(EX_MemToReg),
    .flush(flush), .MEM_ready(MEM_ready), .MEM_valid(MEM_valid),
    .MEM_ALUResult(MEM_ALUResult), .MEM_data2(MEM_data2), .MEM_rd(MEM_rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite),
    .MEM_VRegWrite(MEM_VRegWrite), .MEM_MemToReg(MEM_MemToReg),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Capacity of the block: two entries with the skid, one without.
  function automatic bit model_ready();
`ifdef EX_MEM_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (MEM_ready == 1'b1);
`endif
  endfunction

  function automatic tb_pl_t cur_in();
    return '{alu: EX_ALUResult, d2: EX_data2, rd: EX_rd, rw: EX_RegWrite,
             mw: EX_MemWrite, vw: EX_VRegWrite, mtr: EX_MemToReg};
  endfunction

  // Reference model: a FIFO of held instructions.
  initial begin
    bit acc;
    forever begin
      @(posedge clk or posedge rst);
      if (rst || flush) begin
        mq.delete();
      end else begin
        acc = EX_valid && model_ready();
        if (mq.size() != 0 && MEM_ready) void'(mq.pop_front());
        if (acc) mq.push_back(cur_in());
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("mem_valid", 32'(MEM_valid), 32'(mq.size() != 0));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("ex_ready", 32'(EX_ready), 32'(model_ready()));
      if (mq.size() != 0) begin
        chk("alu", MEM_ALUResult, mq[0].alu);
        chk("data2", MEM_data2, mq[0].d2);
        chk("rd", 32'(MEM_rd), 32'(mq[0].rd));
        chk("ctl", 32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite, MEM_MemToReg}),
            32'({mq[0].rw, mq[0].mw, mq[0].vw, mq[0].mtr}));
        if (streaming && MEM_ready) got.push_back(MEM_ALUResult);
      end else begin
        chk("ctl_idle", 32'({MEM_RegWrite, MEM_MemWrite, MEM_VRegWrite}), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                        input logic rw, input logic mw);
    EX_valid     = v;
    EX_ALUResult = alu;
    EX_data2     = alu ^ 32'hFFFF_0000;
    EX_rd        = rd;
    EX_RegWrite  = rw;
    EX_MemWrite  = mw;
    EX_VRegWrite = alu[0];
    EX_MemToReg  = alu[2:1];
  endtask

  initial begin
    int i;
    logic rdy;
    rst = 1'b1;
    flush = 1'b0;
    MEM_ready = 1'b0;
    set_ex(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", 32'(MEM_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ready", 32'(EX_ready), 32'd1);
    chk("rst_alu", MEM_ALUResult, 32'd0);

    // Empty pass-through.
    set_ex(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
    MEM_ready = 1'b1;
    tick();
    chk("pt_valid", 32'(MEM_valid), 32'd1);
    chk("pt_alu", MEM_ALUResult, 32'h0000_1234);
    chk("pt_rd", 32'(MEM_rd), 32'd5);
    chk("pt_occ", 32'(occupancy), 32'd1);
    EX_valid = 1'b0;
    tick();
    chk("pt_drain", 32'(occupancy), 32'd0);

    // Backpressure.
    MEM_ready = 1'b0;
    set_ex(1'b1, 32'h0000_000A, 5'd1, 1'b1, 1'b0);
    tick();
    set_ex(1'b1, 32'h0000_000B, 5'd2, 1'b1, 1'b1);
    tick();
    chk("bp_alu", MEM_ALUResult, 32'h0000_000A);
`ifdef EX_MEM_SKID_EN
    chk("bp_occ", 32'(occupancy), 32'd2);
`else
    chk("bp_occ", 32'(occupancy), 32'd1);
`endif
    chk("bp_ready", 32'(EX_ready), 32'd0);
    MEM_ready = 1'b1;
`ifdef EX_MEM_SKID_EN
    EX_valid = 1'b0;
`endif
    tick();
    chk("bp_next", MEM_ALUResult, 32'h0000_000B);
    chk("bp_next_occ", 32'(occupancy), 32'd1);
    EX_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(MEM_valid), 32'd0);

    // Flush with a full block and a same-cycle input.
    MEM_ready = 1'b0;
    set_ex(1'b1, 32'h0000_00A1, 5'd3, 1'b0, 1'b1);
    tick();
    set_ex(1'b1, 32'h0000_00B1, 5'd4, 1'b0, 1'b1);
    tick();
    set_ex(1'b1, 32'h0000_00C1, 5'd6, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    chk("fl_valid", 32'(MEM_valid), 32'd0);
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_mw", 32'(MEM_MemWrite), 32'd0);
    flush = 1'b0;
    EX_valid = 1'b0;
    MEM_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_gone", 32'(MEM_valid), 32'd0);
    end

    // Asynchronous reset between edges while full.
    MEM_ready = 1'b0;
    set_ex(1'b1, 32'h0000_0DA1, 5'd7, 1'b1, 1'b0);
    tick();
    set_ex(1'b1, 32'h0000_0DB1, 5'd8, 1'b1, 1'b0);
    tick();
    EX_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(MEM_valid), 32'd0);
    chk("ar_alu", MEM_ALUResult, 32'd0);
    chk("ar_occ", 32'(occupancy), 32'd0);
    tick();
    rst = 1'b0;

    // First accept after reset behaves as on an empty block.
    set_ex(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
    MEM_ready = 1'b1;
    tick();
    chk("ar_pt_alu", MEM_ALUResult, 32'h0000_1234);
    chk("ar_pt_occ", 32'(occupancy), 32'd1);
    EX_valid = 1'b0;
    tick();

    // Streaming with random backpressure.
    got.delete();
    streaming = 1'b1;
    i = 0;
    for (int c = 0; c < 2000 && (i < 100 || got.size() < 100); c++) begin
      if (i < 100) set_ex(1'b1, 32'h0000_0100 + 32'(i), 5'(i), 1'(i), 1'(i >> 1));
      else EX_valid = 1'b0;
      MEM_ready = 1'($urandom_range(0, 1));
      #1;
      rdy = EX_ready;
`ifdef EX_MEM_SKID_EN
      MEM_ready = ~MEM_ready;
      #1;
      chk("no_comb_path", 32'(EX_ready), 32'(rdy));
      MEM_ready = ~MEM_ready;
`endif
      tick();
      if (EX_valid && rdy) i++;
    end
    streaming = 1'b0;
    EX_valid = 1'b0;
    chk("stream_count", 32'(got.size()), 32'd100);
    for (int k = 0; k < 100 && k < got.size(); k++) begin
      chk("stream_order", got[k], 32'h0000_0100 + 32'(k));
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
